// File: rtl/seq_divider_pkg.sv
// Shared ALU divider definitions: FSM states, default width and latency,
// and the quotient returned for a zero divisor.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } div_state_e;

    localparam int WIDTH_DEF   = 32;
    localparam int DIV_LATENCY = WIDTH_DEF + 1;

    localparam logic signed [WIDTH_DEF-1:0] DIV0_QUO = '1;

endpackage

// File: rtl/seq_divider_div_step.sv
// One radix-2 restoring division iteration: shift {rem, quo} left by one,
// then subtract the divisor when the shifted remainder is large enough.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH+1:0] rem_sh;
    logic [WIDTH-1:0] quo_sh;

    always_comb begin
        rem_sh = {rem_i, quo_i[WIDTH-1]};
        quo_sh = {quo_i[WIDTH-2:0], 1'b0};
        rem_o  = rem_sh[WIDTH:0];
        quo_o  = quo_sh;
        if (rem_sh >= {2'b00, dvsr_i}) begin
            rem_o = (WIDTH+1)'(rem_sh - {2'b00, dvsr_i});
            quo_o = quo_sh | WIDTH'(1);
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative signed divider: magnitude restoring division over WIDTH cycles,
// followed by a sign-correction cycle. Quotient truncates toward zero.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quoOut,
    output logic [WIDTH-1:0] remOut,
    output logic             divByZero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic [WIDTH-1:0] quo_out_q, quo_out_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] quo_nx;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (rem_nx),
        .quo_o  (quo_nx)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        qsign_d   = qsign_q;
        rsign_d   = rsign_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (src2 == '0) begin
                        quo_out_d = WIDTH'(DIV0_QUO);
                        rem_out_d = src1;
                        dbz_d     = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        // quo_q doubles as the dividend shift register
                        quo_d   = cond_neg(src1, src1[WIDTH-1]);
                        dvsr_d  = cond_neg(src2, src2[WIDTH-1]);
                        qsign_d = src1[WIDTH-1] ^ src2[WIDTH-1];
                        rsign_d = src1[WIDTH-1];
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = SIGN;
            end
            SIGN: begin
                quo_out_d = cond_neg(quo_q, qsign_q);
                rem_out_d = cond_neg(rem_q[WIDTH-1:0], rsign_q);
                dbz_d     = 1'b0;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            qsign_q   <= 1'b0;
            rsign_q   <= 1'b0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            dbz_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            qsign_q   <= qsign_d;
            rsign_q   <= rsign_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            dbz_q     <= dbz_d;
            done_q    <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign quoOut    = quo_out_q;
    assign remOut    = rem_out_q;
    assign divByZero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed and random divides checked against a
// plain-arithmetic signed division model, plus handshake and reset cases.
module tb_seq_divider;

    localparam int LAT = 33;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] src1, src2;
    logic        busy, done, divByZero;
    logic [31:0] quoOut, remOut;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .src1      (src1),
        .src2      (src2),
        .busy      (busy),
        .done      (done),
        .quoOut    (quoOut),
        .remOut    (remOut),
        .divByZero (divByZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit signed arithmetic avoids the -2^31/-1 overflow trap
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa, sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            z  = 1'b0;
        end
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit pre,
                          input int rep, input bit chain,
                          input logic [31:0] na, input logic [31:0] nb);
        logic [31:0] eq, er;
        logic        ez;
        int          done_at, busy_cnt, exp_lat;
        model(a, b, eq, er, ez);
        if (!pre) begin
            @(negedge clk);
            src1 = a; src2 = b; start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0; src1 = $urandom; src2 = $urandom;
        done_at = -1; busy_cnt = 0;
        for (int i = 0; i <= 40; i++) begin
            if (i > 0) @(negedge clk);
            if (busy) busy_cnt++;
            if (i == rep - 1) begin src1 = $urandom; src2 = $urandom | 32'd1; start = 1'b1; end
            if (i == rep) start = 1'b0;
            if (chain && i == LAT - 1) begin src1 = na; src2 = nb; start = 1'b1; end
            if (done) begin done_at = i; break; end
        end
        exp_lat = (b == 32'd0) ? 0 : LAT;
        check("latency", 64'(done_at), 64'(exp_lat));
        check("busy_cycles", 64'(busy_cnt), 64'(exp_lat));
        check("quo", 64'(quoOut), 64'(eq));
        check("rem", 64'(remOut), 64'(er));
        check("div0", 64'(divByZero), 64'(ez));
        if (!chain) begin
            @(negedge clk);
            check("done_pulse", 64'(done), 64'd0);
            check("hold_quo", 64'(quoOut), 64'(eq));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_quo"}, 64'(quoOut), 64'd0);
        check({tag, "_rem"}, 64'(remOut), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_div0"}, 64'(divByZero), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        rst_n = 1'b0; start = 1'b0; src1 = '0; src2 = '0;
        #1;
        check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_div(32'd100, 32'd7, 1'b0, -1, 1'b0, '0, '0);
        do_div(-32'sd100, 32'd7, 1'b0, -1, 1'b0, '0, '0);
        do_div(32'd100, -32'sd7, 1'b0, -1, 1'b0, '0, '0);
        do_div(-32'sd100, -32'sd7, 1'b0, -1, 1'b0, '0, '0);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, 1'b0, '0, '0);
        do_div(32'd0, 32'd5, 1'b0, -1, 1'b0, '0, '0);
        do_div(32'd3, 32'd5, 1'b0, -1, 1'b0, '0, '0);
        do_div(32'd5, 32'd0, 1'b0, -1, 1'b0, '0, '0);
        do_div(32'd6, 32'd3, 1'b0, -1, 1'b0, '0, '0);

        // second start at T+10 must be ignored
        do_div(32'd1234, -32'sd11, 1'b0, 10, 1'b0, '0, '0);

        // start held through the done cycle launches the next divide
        do_div(32'd77, 32'd5, 1'b0, -1, 1'b1, -32'sd9, 32'd2);
        do_div(-32'sd9, 32'd2, 1'b1, -1, 1'b0, '0, '0);

        // asynchronous reset mid-CALC
        @(negedge clk);
        src1 = 32'd1000; src2 = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        do_div(32'd81, 32'd9, 1'b0, -1, 1'b0, '0, '0);

        for (int n = 0; n < 20; n++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? 32'($signed($urandom_range(0, 2000)) - 1000) : $urandom;
            if (n % 5 == 1) ra = ra >> $urandom_range(0, 31);
            do_div(ra, rb, 1'b0, -1, 1'b0, '0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
